// File: rtl/fifo_out_pkg.sv
// fifo_out_stage shared types: packet FSM state, ctrl defaults, ctrl helper.
// Optional statistics are enabled with the STATS_EN macro.
package fifo_out_pkg;

    localparam int CTRL_W_DEF = 8;

    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } pkt_state_t;

    function automatic logic is_ctrl(input logic [CTRL_W_DEF-1:0] ctrl);
        return (ctrl != '0);
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry holding buffer that absorbs the FIFO's one-cycle read latency.
// Pointer-based, so the head word never moves while it is stalled.
module fifo_out_skid
    import fifo_out_pkg::*;
#(
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_occ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= ~r_wr;
            end
            if (i_pop) begin
                r_rd <= ~r_rd;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd];

endmodule

// File: rtl/fifo_out_stage.sv
// Drain stage for a registered-output FIFO with packet tracking.
// Define STATS_EN to build the word/packet counters.
module fifo_out_stage
    import fifo_out_pkg::*;
#(
    parameter int WIDTH      = 72,
    parameter int CTRL_WIDTH = CTRL_W_DEF,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_rdy,
    output logic                 out_eop,
    input  logic                 stats_clr,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);

    logic             r_inflight;
    pkt_state_t       r_state;
    pkt_state_t       w_state_nxt;
    logic [1:0]       w_occ;
    logic [WIDTH-1:0] w_head;
    logic             w_pop;
    logic             w_ctrl;
    logic [2:0]       w_level;

    fifo_out_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_inflight),
        .i_din   (fifo_dout),
        .i_pop   (w_pop),
        .o_occ   (w_occ),
        .o_head  (w_head)
    );

    assign out_valid = (w_occ != 2'd0);
    assign out_data  = w_head;
    assign w_pop     = out_valid && out_rdy;
    assign w_ctrl    = is_ctrl(w_head[WIDTH-1 -: CTRL_WIDTH]);

    // Counting this cycle's pop lets a full buffer keep streaming.
    assign w_level    = {1'b0, w_occ} + {2'b0, r_inflight}
                      - {2'b0, w_pop};
    assign fifo_rd_en = !fifo_empty && (w_level < 3'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HDR: begin
                if (w_pop && !w_ctrl) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_pop && w_ctrl) begin
                    w_state_nxt = HDR;
                end
            end
            default: w_state_nxt = HDR;
        endcase
    end

    always_comb begin
        out_eop = 1'b0;
        if (r_state == DATA) begin
            out_eop = w_ctrl && out_valid;
        end
    end

`ifdef STATS_EN
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic [CNT_WIDTH-1:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else if (stats_clr) begin
            r_word_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (out_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign word_cnt = r_word_cnt;
    assign pkt_cnt  = r_pkt_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = stats_clr;
    assign word_cnt     = '0;
    assign pkt_cnt      = '0;
`endif

endmodule

// File: doc/fifo_out_stage.md
# fifo_out_stage

Drain stage downstream of the registered-output (non-fallthrough) small FIFO. It issues reads to the FIFO, absorbs the one-cycle read latency in a 2-entry holding buffer, and presents words on a valid/ready stream that can stall at any cycle without losing data or throughput. It also tracks packet boundaries using the NetFPGA ctrl/data word convention, and optionally counts words and packets.

## Interface
- WIDTH, 72, full word width; ctrl occupies the top CTRL_WIDTH bits.
- CTRL_WIDTH, 8, ctrl field width (word bits WIDTH-1 down to WIDTH-CTRL_WIDTH).
- CNT_WIDTH, 32, statistics counter width.
- clk  in  1  single clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_dout  in  WIDTH  FIFO data; valid in the cycle after fifo_rd_en was high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe (combinational).
- out_data  out  WIDTH  head word of the holding buffer.
- out_valid  out  1  out_data is valid.
- out_rdy  in  1  consumer accepts; a transfer occurs when out_valid && out_rdy.
- out_eop  out  1  head word is the last word of a packet.
- stats_clr  in  1  synchronous clear of the counters.
- word_cnt  out  CNT_WIDTH  words transferred.
- pkt_cnt  out  CNT_WIDTH  packets transferred (eop transfers).

## Operation
- Holding buffer: 2 entries with occupancy occ (0..2). inflight (0/1) is set in the cycle after fifo_rd_en is high.
- pop = out_valid && out_rdy.
- fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2. The combinational path from out_rdy to fifo_rd_en is intentional and required for full throughput.
- When inflight is 1, fifo_dout is written into the buffer at the end of that cycle. Push and pop in the same cycle leave occ unchanged.
- out_valid = (occ != 0). out_data is the oldest entry, FIFO order is preserved, and out_data is held stable while out_valid && !out_rdy.
- Packet FSM, evaluated on the head word:
  - States: HDR (reset state) and DATA.
  - HDR: a head word with ctrl == 0 moves the FSM to DATA when it is popped.
  - DATA: a head word with ctrl != 0 is eop. out_eop is 1 for that word, and its pop returns the FSM to HDR.
  - out_eop = (state == DATA) && (head ctrl != 0) && out_valid.
- Counters: word_cnt += 1 on each pop. pkt_cnt += 1 on each pop with out_eop. Both wrap modulo 2^CNT_WIDTH. stats_clr wins over a same-cycle increment.
- Boundaries:
  - The block never reads an empty FIFO and never overflows the buffer; occ + inflight never exceeds 2.
  - fifo_empty rising while a read is inflight does not affect the inflight word.
  - reset_n asserted mid-operation clears occ, inflight, state and counters immediately. Inflight data is dropped; the FIFO is reset separately.

## Timing
- Reset values: fifo_rd_en = 0 while fifo_empty is high, out_valid = 0, out_eop = 0, out_data = 0, word_cnt = 0, pkt_cnt = 0, state = HDR.
- Latency: with the buffer empty and the FIFO non-empty at cycle t, fifo_rd_en is high at t, the word is captured at the end of t+1, and out_valid is high at t+2.
- Throughput: 1 word per cycle while the FIFO is non-empty and out_rdy is held high.
- Stall: after out_rdy drops, at most one further FIFO read completes. The buffer then holds 2 words and fifo_rd_en stays low until a pop.

## Configuration
- STATS_EN defined: word_cnt and pkt_cnt are implemented as above.
- STATS_EN undefined: the counters are not synthesized, word_cnt and pkt_cnt are driven constant 0, and stats_clr is ignored. The ports remain present so instantiations are unchanged.

## Structure
- Package fifo_out_pkg: the packet FSM state type (HDR, DATA), the default CTRL_WIDTH, and a helper function is_ctrl(word) returning (ctrl != 0).
- One sub-module, fifo_out_skid: the 2-entry holding buffer with push, pop, occ and head outputs. The top level contains the read-issue logic, the FSM and the counters.

## Test plan
- FIFO preloaded with 8 words, out_rdy held at 1 -> first out_valid at t+2, then 8 consecutive words in order, fifo_rd_en high for 8 consecutive cycles.
- out_rdy held at 0 with 4 words queued -> exactly 2 words buffered, fifo_rd_en low, out_data stable. out_rdy then raised -> remaining words delivered with no loss or duplication.
- Packet: 1 header word (ctrl = 0xFF), 3 data words (ctrl = 0), last word (ctrl = 0x10) -> out_eop high only on the fifth word; with STATS_EN defined, pkt_cnt = 1 and word_cnt = 5.
- Random out_rdy with 50% duty over 200 words -> output sequence identical to input; no read issued while fifo_empty is high.
- reset_n pulsed low while occ = 2 and a read is inflight -> out_valid = 0 immediately, counters = 0, state = HDR; first post-reset word is delivered correctly.
- STATS_EN undefined, same traffic as the packet scenario -> word_cnt = 0 and pkt_cnt = 0 throughout, data path identical.
